// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer handshake and uart_tx launch signals shared by the arbiter.
// master is the arbiter side; slave is the producers plus the uart_tx instance.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_done;

    modport master (
        input  req_valid,
        input  req_data,
        input  tx_done,
        output req_ready,
        output tx_start,
        output tx_data
    );

    modport slave (
        output req_valid,
        output req_data,
        output tx_done,
        input  req_ready,
        input  tx_start,
        input  tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte producers.
// One byte per grant: accept, pulse tx_start, wait for tx_done or timeout, idle one cycle.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 2047,
    localparam int GNT_W  = $clog2(NUM_REQ),
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.master bus,
    output logic [GNT_W-1:0]  grant_id,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [GNT_W-1:0] last_grant;
    logic [GNT_W-1:0] win_id;
    logic [GNT_W-1:0] cand;
    logic             win_vld;
    logic             accept;
    logic             tmo_hit;
    logic [CNT_W-1:0] wait_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(TIMEOUT)) ? v : v + 1'b1;
    endfunction

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GNT_W'((int'(last_grant) + k) % NUM_REQ);
            if (!win_vld && bus.req_valid[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    assign accept  = (state == IDLE) && win_vld;
    assign tmo_hit = (wait_cnt == CNT_W'(TIMEOUT));
    assign busy    = (state != IDLE);

    // Ready is forced low while reset is held, even though the state is already IDLE.
    always_comb begin
        bus.req_ready = '0;
        if (accept && reset) begin
            bus.req_ready[win_id] = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.tx_start = 1'b0;
        timeout_err  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                bus.tx_start = 1'b1;
                state_nxt    = WAIT;
            end
            WAIT: begin
                // A completion on the timeout cycle still counts as success.
                if (bus.tx_done) begin
                    state_nxt = GAP;
                end else if (tmo_hit) begin
                    timeout_err = 1'b1;
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bus.tx_data <= '0;
            grant_id    <= '0;
            last_grant  <= GNT_W'(NUM_REQ - 1);
            wait_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                bus.tx_data <= bus.req_data[win_id*DATA_W +: DATA_W];
                grant_id    <= win_id;
            end
            if (state == WAIT) begin
                wait_cnt <= sat_inc(wait_cnt);
                if (state_nxt == GAP) begin
                    last_grant <= grant_id;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    a_ready_onehot : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(bus.req_ready));

    a_err_not_done : assert property (@(posedge clk) disable iff (!reset)
        !(timeout_err && bus.tx_done));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a transaction-level round-robin model predicts
// each winner, byte, launch cycle and timeout pulse.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TMO  = 15;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  int n_tests    = 0;
  int n_fail     = 0;
  int model_last = NREQ - 1;

  uart_tx_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Winner = valid requester with the smallest rotational distance past the last owner.
  function automatic int model_winner(input logic [3:0] m, input int last);
    int best  = -1;
    int bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (m[i]) begin
        int d;
        d = (i - last - 1 + 2 * NREQ) % NREQ;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic apply_reset();
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.tx_done   = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_ready", bus.req_ready, 0);
    #19;
    reset      = 1'b1;
    model_last = NREQ - 1;
  endtask

  // dly > TMO means tx_done never arrives; spur pulses tx_done during LAUNCH.
  task automatic do_xfer(input logic [3:0] vmask, input logic [31:0] bytes,
                         input int dly, input bit spur);
    int         w;
    logic [7:0] exp_b;
    w     = model_winner(vmask, model_last);
    exp_b = bytes[w*8 +: 8];
    @(posedge clk); #1;
    bus.req_valid = vmask;
    bus.req_data  = bytes;
    @(negedge clk);
    chk("idle_ready", bus.req_ready, 32'(1 << w));
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.req_data  = $urandom;
    bus.tx_done   = spur;
    @(negedge clk);
    chk("launch_start", bus.tx_start, 1);
    chk("launch_data", bus.tx_data, exp_b);
    chk("launch_grant", grant_id, w);
    chk("launch_busy", busy, 1);
    chk("launch_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    bus.tx_done = 1'b0;
    if (dly <= TMO) begin
      for (int c = 0; c < dly; c++) begin
        @(negedge clk);
        chk("wait_start", bus.tx_start, 0);
        chk("wait_tmo", timeout_err, 0);
        chk("wait_busy", busy, 1);
        @(posedge clk); #1;
      end
      bus.tx_done = 1'b1;
      @(negedge clk);
      chk("done_tmo", timeout_err, 0);
      chk("done_data", bus.tx_data, exp_b);
      @(posedge clk); #1;
      bus.tx_done = 1'b0;
    end else begin
      for (int c = 0; c <= TMO; c++) begin
        @(negedge clk);
        chk("tmo_pulse", timeout_err, (c == TMO));
        chk("tmo_start", bus.tx_start, 0);
        if (c < TMO) begin
          @(posedge clk); #1;
        end
      end
      @(posedge clk); #1;
    end
    bus.req_valid = vmask;
    @(negedge clk);
    chk("gap_busy", busy, 1);
    chk("gap_ready", bus.req_ready, 0);
    chk("gap_tmo", timeout_err, 0);
    chk("gap_grant", grant_id, w);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("end_busy", busy, 0);
    model_last = w;
  endtask

  task automatic spur_idle();
    @(posedge clk); #1;
    bus.tx_done = 1'b1;
    @(negedge clk);
    chk("spur_busy", busy, 0);
    chk("spur_ready", bus.req_ready, 0);
    chk("spur_start", bus.tx_start, 0);
    @(posedge clk); #1;
    bus.tx_done = 1'b0;
    @(negedge clk);
    chk("spur_after", busy, 0);
  endtask

  initial begin
    logic [3:0]  m;
    logic [31:0] b;
    int          d;
    int          w;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    #1;
    apply_reset();

    do_xfer(4'b0100, 32'h00A5_0000, 3, 1'b0);

    apply_reset();
    for (int i = 0; i < 5; i++) do_xfer(4'b1111, 32'h1312_1110, $urandom_range(0, 4), 1'b0);

    apply_reset();
    do_xfer(4'b1001, 32'h7700_0055, 1, 1'b0);
    do_xfer(4'b1001, 32'h7700_0055, 1, 1'b0);

    do_xfer(4'b0110, 32'hCAFE_BEEF, TMO + 1, 1'b0);
    do_xfer(4'b0110, 32'hCAFE_BEEF, 2, 1'b0);
    do_xfer(4'b0001, 32'h0000_003C, TMO, 1'b0);

    w = model_winner(4'b0010, model_last);
    @(posedge clk); #1;
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h0000_9900;
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_grant", grant_id, w);
    @(posedge clk); #3;
    bus.req_valid = 4'b1001;
    reset         = 1'b0;
    #1;
    chk("mid_rst_start", bus.tx_start, 0);
    chk("mid_rst_data", bus.tx_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", bus.req_ready, 0);
    @(negedge clk);
    reset         = 1'b1;
    bus.req_valid = '0;
    model_last    = NREQ - 1;
    do_xfer(4'b1001, 32'h4400_0021, 2, 1'b0);

    spur_idle();
    do_xfer(4'b0100, 32'h005A_0000, 3, 1'b1);

    for (int i = 0; i < 40; i++) begin
      m = 4'($urandom_range(1, 15));
      b = $urandom;
      d = $urandom_range(0, 9);
      if (d < 2)       d = TMO + 1;
      else if (d == 2) d = TMO;
      else             d = $urandom_range(0, 6);
      if ($urandom_range(0, 5) == 0) spur_idle();
      do_xfer(m, b, d, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
